// File: rtl/tex_pkg.sv
// Shared types for the texture fetch master.
// Request word layout, FSM states and RGB word ordering.
package tex_pkg;

  localparam int CORE_ID_W  = 7;
  localparam int TEX_ADDR_W = 24;
  localparam int NUM_CORES  = 87;
  localparam int RESP_W     = CORE_ID_W + 32;

  typedef struct packed {
    logic                  pad;
    logic [CORE_ID_W-1:0]  core_id;
    logic [TEX_ADDR_W-1:0] addr;
  } tex_req_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_CAPTURE,
    R_ISSUE
  } req_st_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_DATA,
    D_ID
  } drn_st_e;

  // Each response goes out as texel data first, then the core ID word.
  typedef enum logic {
    RGB_DATA = 1'b0,
    RGB_ID   = 1'b1
  } rgb_word_e;

  function automatic logic [31:0] rgb_word(
    input rgb_word_e          sel,
    input logic [RESP_W-1:0]  ent
  );
    if (sel == RGB_DATA)
      return ent[31:0];
    return {25'b0, ent[RESP_W-1:32]};
  endfunction

endpackage

// File: rtl/tex_sync_fifo.sv
// Show-ahead synchronous FIFO: o_q is the head entry while !o_empty.
// Ports: i_push/i_data write, i_pop advance, o_full/o_empty flags.
module tex_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_q,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wp;
  logic [PW:0]      r_rp;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[PW] != r_rp[PW]) &&
                   (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign o_q     = r_mem[r_rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp[PW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
    end
  end

endmodule

// File: rtl/texture_fetch_master.sv
// Texture read engine: pops {core_id, texel} requests, reads texture
// memory over Avalon-MM, pushes data/ID word pairs into FIFO_RGB.
// Ports: FF_texture_* request FIFO, avm_* memory master,
// FF_rgb_* response FIFO, busy/proto_err/fetch_count status.
module texture_fetch_master
  import tex_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] TEX_BASE        = 32'h0000_0000,
  parameter int          AW              = 32,
  parameter int          CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             FF_texture_empty,
  output logic             FF_texture_readreq,
  input  logic [31:0]      FF_texture_q,
  output logic [AW-1:0]    avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  input  logic             FF_rgb_almostfull,
  output logic             FF_rgb_writerequest,
  output logic [31:0]      FF_rgb_data,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = (AW > 32) ? AW : 32;

  req_st_e              r_req_st;
  req_st_e              w_req_nx;
  drn_st_e              r_drn_st;
  drn_st_e              w_drn_nx;
  logic [IW-1:0]        r_inflight;
  logic [AW-1:0]        r_addr;
  logic                 r_run;
  logic                 r_proto_err;
  logic [CNT_W-1:0]     r_cnt;

  tex_req_t             w_req;
  logic [SW-1:0]        w_byte_addr;
  logic                 w_unused;
  logic                 w_pop_req;
  logic                 w_rd;
  logic                 w_tag_push;
  logic                 w_tag_pop;
  logic [CORE_ID_W-1:0] w_tag_q;
  logic                 w_tag_full;
  logic                 w_tag_empty;
  logic                 w_rdv_ok;
  logic                 w_resp_push;
  logic                 w_resp_pop;
  logic [RESP_W-1:0]    w_resp_q;
  logic                 w_resp_full;
  logic                 w_resp_empty;
  logic                 w_wr;
  logic [31:0]          w_wdata;

  assign w_req       = tex_req_t'(FF_texture_q);
  assign w_unused    = w_req.pad;
  assign w_byte_addr = SW'(TEX_BASE) + SW'({w_req.addr, 2'b00});

  always_comb begin
    w_req_nx   = r_req_st;
    w_pop_req  = 1'b0;
    w_rd       = 1'b0;
    w_tag_push = 1'b0;
    unique case (r_req_st)
      R_IDLE: begin
        w_pop_req = r_run && !FF_texture_empty &&
                    (r_inflight < IW'(MAX_OUTSTANDING));
        if (w_pop_req)
          w_req_nx = R_CAPTURE;
      end
      R_CAPTURE: begin
        w_tag_push = !w_tag_full;
        w_req_nx   = R_ISSUE;
      end
      R_ISSUE: begin
        w_rd = 1'b1;
        if (!avm_waitrequest)
          w_req_nx = R_IDLE;
      end
      default: w_req_nx = R_IDLE;
    endcase
  end

  // A beat with no tag to pair with is dropped and flagged.
  assign w_rdv_ok    = avm_readdatavalid && !w_tag_empty;
  assign w_tag_pop   = w_rdv_ok;
  assign w_resp_push = w_rdv_ok && !w_resp_full;

  always_comb begin
    w_drn_nx   = r_drn_st;
    w_wr       = 1'b0;
    w_wdata    = '0;
    w_resp_pop = 1'b0;
    unique case (r_drn_st)
      D_IDLE: begin
        if (!w_resp_empty && !FF_rgb_almostfull)
          w_drn_nx = D_DATA;
      end
      D_DATA: begin
        w_wr     = 1'b1;
        w_wdata  = rgb_word(RGB_DATA, w_resp_q);
        w_drn_nx = D_ID;
      end
      D_ID: begin
        w_wr       = 1'b1;
        w_wdata    = rgb_word(RGB_ID, w_resp_q);
        w_resp_pop = 1'b1;
        w_drn_nx   = D_IDLE;
      end
      default: w_drn_nx = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_st    <= R_IDLE;
      r_drn_st    <= D_IDLE;
      r_inflight  <= '0;
      r_addr      <= '0;
      r_run       <= 1'b0;
      r_proto_err <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_req_st <= w_req_nx;
      r_drn_st <= w_drn_nx;
      r_run    <= 1'b1;
      if (r_req_st == R_CAPTURE)
        r_addr <= w_byte_addr[AW-1:0];
      unique case ({r_req_st == R_CAPTURE, w_resp_pop})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: ;
      endcase
      if (avm_readdatavalid && w_tag_empty)
        r_proto_err <= 1'b1;
      if (w_resp_pop)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  tex_sync_fifo #(
    .WIDTH (CORE_ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tag_push),
    .i_data  (w_req.core_id),
    .i_pop   (w_tag_pop),
    .o_q     (w_tag_q),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  tex_sync_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_resp_push),
    .i_data  ({w_tag_q, avm_readdata}),
    .i_pop   (w_resp_pop),
    .o_q     (w_resp_q),
    .o_full  (w_resp_full),
    .o_empty (w_resp_empty)
  );

  assign FF_texture_readreq  = w_pop_req;
  assign avm_read            = w_rd;
  assign avm_address         = r_addr;
  assign FF_rgb_writerequest = w_wr;
  assign FF_rgb_data         = w_wdata;
  assign busy                = (r_inflight != '0) || (r_req_st != R_IDLE);
  assign proto_err           = r_proto_err;
  assign fetch_count         = r_cnt;

endmodule

// File: tb/tb_texture_fetch_master.sv
// Bench for texture_fetch_master: FIFO, slave and sink models
// with an expected-word scoreboard, one task per scenario.
module tb_texture_fetch_master;
  import tex_pkg::*;

  localparam logic [31:0] TB_BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        FF_texture_empty;
  logic        FF_texture_readreq;
  logic [31:0] FF_texture_q;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        FF_rgb_almostfull;
  logic        FF_rgb_writerequest;
  logic [31:0] FF_rgb_data;
  logic        busy;
  logic        proto_err;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  texture_fetch_master #(
    .MAX_OUTSTANDING (4),
    .TEX_BASE        (TB_BASE),
    .AW              (32),
    .CNT_W           (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .FF_texture_empty    (FF_texture_empty),
    .FF_texture_readreq  (FF_texture_readreq),
    .FF_texture_q        (FF_texture_q),
    .avm_address         (avm_address),
    .avm_read            (avm_read),
    .avm_waitrequest     (avm_waitrequest),
    .avm_readdata        (avm_readdata),
    .avm_readdatavalid   (avm_readdatavalid),
    .FF_rgb_almostfull   (FF_rgb_almostfull),
    .FF_rgb_writerequest (FF_rgb_writerequest),
    .FF_rgb_data         (FF_rgb_data),
    .busy                (busy),
    .proto_err           (proto_err),
    .fetch_count         (fetch_count)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] tq[$];
  logic [31:0] aq[$];
  logic [31:0] dq[$];
  logic [31:0] rq[$];
  logic [31:0] sbq[$];
  logic [31:0] wlog[$];

  int   stall_left = 0;
  bit   hold_resp = 0;
  bit   force_rdv = 0;
  bit   af = 0;
  bit   pop_pend = 0;
  bit   in_pair = 0;
  bit   stalled = 0;
  logic [31:0] pop_val;
  logic [31:0] stall_addr;
  logic [31:0] last_acc_addr = '0;
  logic [31:0] m_exp;
  int   cyc = 0;
  int   n_pops = 0;
  int   n_reads = 0;
  int   n_rd_cyc = 0;
  int   n_wr = 0;
  int   t_pop = -1;
  int   t_first_rd = -1;
  int   t_last_pop = -1000;
  int   min_gap = 1000;

  // Models: drive inputs at negedge, sample 1 ns later (what the next
  // posedge will see), then update model state.
  initial begin
    FF_texture_empty  = 1'b1;
    FF_texture_q      = '0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = '0;
    avm_readdatavalid = 1'b0;
    FF_rgb_almostfull = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_pend) begin
        FF_texture_q = pop_val;
        pop_pend = 0;
      end
      FF_texture_empty = (tq.size() == 0);
      avm_waitrequest  = (stall_left > 0);
      if (force_rdv) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_BEEF;
        force_rdv         = 0;
      end else if (!hold_resp && rq.size() > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rq.pop_front();
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
      end
      FF_rgb_almostfull = af;
      #1;
      if (rst_n) begin
        if (FF_texture_readreq) begin
          n_pops++;
          if (tq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_empty: readreq=1 required 0");
          end else begin
            pop_val  = tq.pop_front();
            pop_pend = 1;
          end
          if (cyc - t_last_pop < min_gap)
            min_gap = cyc - t_last_pop;
          t_last_pop = cyc;
          t_pop      = cyc;
        end
        if (avm_read) begin
          n_rd_cyc++;
          if (t_first_rd < 0)
            t_first_rd = cyc;
          if (stalled) begin
            n_vec++;
            if (avm_address !== stall_addr) begin
              n_err++;
              $display("FAIL addr_stable: got %h required %h",
                       avm_address, stall_addr);
            end
          end
          if (avm_waitrequest) begin
            stall_left--;
            stalled    = 1;
            stall_addr = avm_address;
          end else begin
            stalled = 0;
            n_reads++;
            last_acc_addr = avm_address;
            n_vec++;
            if (aq.size() == 0) begin
              n_err++;
              $display("FAIL read_extra: addr %h, no read expected",
                       avm_address);
              rq.push_back(32'h0);
            end else begin
              m_exp = aq.pop_front();
              if (avm_address !== m_exp) begin
                n_err++;
                $display("FAIL avm_address: got %h required %h",
                         avm_address, m_exp);
              end
              rq.push_back(dq.pop_front());
            end
          end
        end
        n_vec++;
        if (FF_rgb_writerequest) begin
          n_wr++;
          wlog.push_back(FF_rgb_data);
          in_pair = !in_pair;
          if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL rgb_extra: data %h, no write expected",
                     FF_rgb_data);
          end else begin
            m_exp = sbq.pop_front();
            if (FF_rgb_data !== m_exp) begin
              n_err++;
              $display("FAIL rgb_data: got %h required %h",
                       FF_rgb_data, m_exp);
            end
          end
        end else if (in_pair) begin
          n_err++;
          in_pair = 0;
          $display("FAIL pair_split: writerequest=0 required 1");
        end else if (FF_rgb_data !== 32'h0) begin
          n_err++;
          $display("FAIL rgb_idle: data %h required 0", FF_rgb_data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic push_req(input logic [31:0] w, input logic [31:0] d);
    tq.push_back(w);
    aq.push_back(TB_BASE + {6'b0, w[23:0], 2'b00});
    dq.push_back(d);
    sbq.push_back(d);
    sbq.push_back({25'b0, w[30:24]});
  endtask

  task automatic wait_cnt(input logic [31:0] tgt, input int budget);
    int k = 0;
    while (fetch_count !== tgt && k < budget) begin
      cycles(1);
      k++;
    end
    n_vec++;
    if (fetch_count !== tgt) begin
      n_err++;
      $display("FAIL wait_cnt: fetch_count %0d required %0d",
               fetch_count, tgt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    n_vec += 8;
    if (FF_texture_readreq !== 1'b0) begin
      n_err++; $display("FAIL rst_readreq: got %b required 0", FF_texture_readreq);
    end
    if (avm_read !== 1'b0) begin
      n_err++; $display("FAIL rst_read: got %b required 0", avm_read);
    end
    if (avm_address !== 32'h0) begin
      n_err++; $display("FAIL rst_addr: got %h required 0", avm_address);
    end
    if (FF_rgb_writerequest !== 1'b0) begin
      n_err++; $display("FAIL rst_wr: got %b required 0", FF_rgb_writerequest);
    end
    if (FF_rgb_data !== 32'h0) begin
      n_err++; $display("FAIL rst_data: got %h required 0", FF_rgb_data);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rst_busy: got %b required 0", busy);
    end
    if (proto_err !== 1'b0) begin
      n_err++; $display("FAIL rst_proto: got %b required 0", proto_err);
    end
    if (fetch_count !== 32'h0) begin
      n_err++; $display("FAIL rst_count: got %0d required 0", fetch_count);
    end
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_single();
    int w0 = n_wr;
    int p0 = n_pops;
    wlog.delete();
    t_first_rd = -1;
    push_req(32'h0500_0010, 32'hAABB_CCDD);
    wait_cnt(32'd1, 40);
    cycles(2);
    n_vec += 6;
    if (last_acc_addr !== 32'h1000_0040) begin
      n_err++; $display("FAIL single_addr: got %h required 10000040", last_acc_addr);
    end
    if (n_wr - w0 != 2) begin
      n_err++; $display("FAIL single_wr: got %0d writes required 2", n_wr - w0);
    end
    if (wlog.size() < 2 || wlog[0] !== 32'hAABB_CCDD || wlog[1] !== 32'h5) begin
      n_err++; $display("FAIL single_words: got %0d words required aabbccdd,00000005", wlog.size());
    end
    if (t_first_rd - t_pop != 2) begin
      n_err++; $display("FAIL single_lat: got %0d required 2", t_first_rd - t_pop);
    end
    if (n_pops - p0 != 1) begin
      n_err++; $display("FAIL single_pops: got %0d required 1", n_pops - p0);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL single_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_waitreq();
    logic [31:0] base = fetch_count;
    int r0 = n_rd_cyc;
    int p0 = n_pops;
    stall_left = 3;
    push_req(32'h2A00_0100, $urandom);
    wait_cnt(base + 1, 60);
    cycles(2);
    n_vec += 2;
    if (n_rd_cyc - r0 != 4) begin
      n_err++; $display("FAIL wait_rdcyc: got %0d required 4", n_rd_cyc - r0);
    end
    if (n_pops - p0 != 1) begin
      n_err++; $display("FAIL wait_pops: got %0d required 1", n_pops - p0);
    end
  endtask

  task automatic test_outstanding();
    logic [31:0] base = fetch_count;
    int p0 = n_pops;
    int w0 = n_wr;
    hold_resp = 1;
    for (int i = 0; i < 6; i++)
      push_req({1'b0, 7'(10 + i), 24'(i * 3)}, $urandom);
    cycles(40);
    n_vec += 4;
    if (n_pops - p0 != 4) begin
      n_err++; $display("FAIL out_pops: got %0d required 4", n_pops - p0);
    end
    if (FF_texture_readreq !== 1'b0) begin
      n_err++; $display("FAIL out_readreq: got %b required 0", FF_texture_readreq);
    end
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL out_busy: got %b required 1", busy);
    end
    if (n_wr != w0) begin
      n_err++; $display("FAIL out_early_wr: got %0d required 0", n_wr - w0);
    end
    hold_resp = 0;
    wait_cnt(base + 6, 200);
    cycles(2);
    n_vec += 3;
    if (n_wr - w0 != 12) begin
      n_err++; $display("FAIL out_wr: got %0d required 12", n_wr - w0);
    end
    if (n_pops - p0 != 6) begin
      n_err++; $display("FAIL out_pops_all: got %0d required 6", n_pops - p0);
    end
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL out_sb: got %0d left required 0", sbq.size());
    end
  endtask

  task automatic test_almostfull();
    logic [31:0] base = fetch_count;
    int w0 = n_wr;
    af = 1;
    push_req(32'h1100_0200, $urandom);
    push_req(32'h1200_0201, $urandom);
    cycles(30);
    n_vec += 2;
    if (n_wr != w0) begin
      n_err++; $display("FAIL af_hold: got %0d writes required 0", n_wr - w0);
    end
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL af_busy: got %b required 1", busy);
    end
    af = 0;
    wait_cnt(base + 2, 60);
    cycles(2);
    n_vec++;
    if (n_wr - w0 != 4) begin
      n_err++; $display("FAIL af_wr: got %0d required 4", n_wr - w0);
    end
  endtask

  task automatic test_proto();
    int w0 = n_wr;
    n_vec += 5;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL proto_idle: busy %b required 0", busy);
    end
    force_rdv = 1;
    cycles(4);
    if (proto_err !== 1'b1) begin
      n_err++; $display("FAIL proto_set: got %b required 1", proto_err);
    end
    if (n_wr != w0) begin
      n_err++; $display("FAIL proto_wr: got %0d required 0", n_wr - w0);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL proto_busy: got %b required 0", busy);
    end
    cycles(10);
    if (proto_err !== 1'b1) begin
      n_err++; $display("FAIL proto_sticky: got %b required 1", proto_err);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    hold_resp = 1;
    push_req(32'h0100_0001, $urandom);
    push_req(32'h0200_0002, $urandom);
    cycles(15);
    stall_left = 1000;
    push_req(32'h0300_0003, $urandom);
    while (avm_read !== 1'b1 && k < 30) begin
      cycles(1);
      k++;
    end
    n_vec += 6;
    if (avm_read !== 1'b1) begin
      n_err++; $display("FAIL mid_issue: avm_read %b required 1", avm_read);
    end
    rst_n = 1'b0;
    #1;
    if (avm_read !== 1'b0) begin
      n_err++; $display("FAIL mid_read: got %b required 0", avm_read);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL mid_busy: got %b required 0", busy);
    end
    if (fetch_count !== 32'h0) begin
      n_err++; $display("FAIL mid_count: got %0d required 0", fetch_count);
    end
    if (proto_err !== 1'b0) begin
      n_err++; $display("FAIL mid_proto: got %b required 0", proto_err);
    end
    if (FF_texture_readreq !== 1'b0) begin
      n_err++; $display("FAIL mid_readreq: got %b required 0", FF_texture_readreq);
    end
    tq.delete(); aq.delete(); dq.delete(); rq.delete(); sbq.delete();
    stall_left = 0;
    hold_resp  = 0;
    pop_pend   = 0;
    in_pair    = 0;
    stalled    = 0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
    push_req(32'h3300_0020, $urandom);
    wait_cnt(32'd1, 40);
    cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] base = fetch_count;
    int p0 = n_pops;
    int w0 = n_wr;
    min_gap    = 1000;
    t_last_pop = -1000;
    push_req(32'hFF00_0003, $urandom);
    push_req(32'h00FF_FFFF, $urandom);
    for (int i = 0; i < 6; i++)
      push_req({1'b0, 7'($urandom_range(0, NUM_CORES - 1)), 24'($urandom)},
               $urandom);
    wait_cnt(base + 8, 300);
    cycles(2);
    n_vec += 5;
    if (n_pops - p0 != 8) begin
      n_err++; $display("FAIL b2b_pops: got %0d required 8", n_pops - p0);
    end
    if (n_wr - w0 != 16) begin
      n_err++; $display("FAIL b2b_wr: got %0d required 16", n_wr - w0);
    end
    if (min_gap != 3) begin
      n_err++; $display("FAIL b2b_gap: got %0d required 3", min_gap);
    end
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL b2b_sb: got %0d left required 0", sbq.size());
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_busy: got %b required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_waitreq();
    test_outstanding();
    test_almostfull();
    test_proto();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
